picorv32_alu_arbiter: RTL and testbench
=======================================

// Module: picorv32_alu_arbiter
// PURPOSE
//   Shares one picorv32_alu instance between two requesters: req 0 is the core FSM and req 1 is a coprocessor port.
//   Accepts at most one operation at a time and arbitrates round-robin (or fixed-priority) between the requesters.
//   Decodes a 4-bit op code into the ALU's one-hot control inputs and drives the ALU operands.
//   Holds control and operands stable for the ALU latency, captures the result and returns it on a valid/ready response channel.
// PARAMETERS
//   TWO_CYCLE_ALU  1'b0  must match the ALU instance; 1 adds one WAIT cycle before result capture
//   ROUND_ROBIN    1'b1  1 = round-robin between requesters; 0 = req 0 always wins
// PORTS
//   clk          in   1   clock; all logic is on posedge
//   reset        in   1   synchronous reset, active-high
//   req_valid    in   2   bit i = requester i has an operation pending
//   req_ready    out  2   bit i = requester i's operation is accepted this cycle
//   req_op       in   8   {op1[3:0], op0[3:0]}; encoding: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 EQ, 6 NE, 7 LT, 8 GE, 9 LTU, 10 GEU
//   req_op1      in   64  {r1[31:0], r0[31:0]} first operand
//   req_op2      in   64  {r1[31:0], r0[31:0]} second operand
//   resp_valid   out  2   one-hot; bit i = response for requester i is valid
//   resp_ready   in   2   bit i = requester i consumes its response
//   resp_result  out  32  captured alu_out
//   resp_cmp     out  1   captured alu_out_0
//   resp_err     out  1   op code was 11..15 (illegal)
//   alu_ctrl     out  15  [14:0] = {and, andi, beq, bge, bgeu, bne, or, ori, sub, xor, xori, is_compare, is_add_sub, is_slt, is_sltu}
//   alu_op1      out  32  drives reg_op1 of the ALU
//   alu_op2      out  32  drives reg_op2 of the ALU
//   alu_out      in   32  result from the ALU
//   alu_out_0    in   1   compare bit from the ALU
// BEHAVIOUR
//   FSM states: IDLE -> ISSUE -> [WAIT, only when TWO_CYCLE_ALU] -> RESP -> IDLE.
//   req_ready is nonzero only in IDLE, and is one-hot: it equals the grant.
//     Grant requires req_valid; accept = req_valid[i] & req_ready[i]; accepting moves the FSM to ISSUE.
//   Arbitration:
//     - Only one requester valid: that requester is granted.
//     - Both valid, ROUND_ROBIN = 1: grant the requester that was not granted last.
//     - Reset sets the last-grant pointer to 1, so req 0 wins the first conflict.
//     - ROUND_ROBIN = 0: req 0 always wins a conflict.
//   On accept, the winner's op, operands and id are registered.
//     alu_op1, alu_op2 and alu_ctrl come from these registers and are held constant through ISSUE and WAIT.
//   Op decode to alu_ctrl:
//     - ADD: is_add_sub.  SUB: is_add_sub + sub.  XOR: xor.  OR: or.  AND: and.
//     - EQ: beq + is_compare.  NE: bne + is_compare.  LT: is_slt + is_compare.
//     - GE: bge + is_compare.  LTU: is_sltu + is_compare.  GEU: bgeu + is_compare.
//     - Illegal op (11..15): alu_ctrl = 0 and resp_err = 1.
//   Result capture:
//     - TWO_CYCLE_ALU = 0: alu_out and alu_out_0 are registered at the end of ISSUE.
//     - TWO_CYCLE_ALU = 1: they are registered at the end of WAIT.
//   Latency:
//     - Accept at cycle T gives resp_valid high from T+2 (TWO_CYCLE_ALU = 0) or T+3 (TWO_CYCLE_ALU = 1).
//   RESP state:
//     - resp_valid[id] = 1; resp_result, resp_cmp and resp_err are held stable until resp_ready[id] = 1.
//     - Handshake cycle: FSM returns to IDLE; the next accept happens one cycle later at the earliest.
//     - resp_ready on the non-owning bit is ignored.
//   Outside ISSUE and WAIT, alu_ctrl = 0 and alu_op1 = alu_op2 = 0.
//     The ALU therefore sees no active op and alu_out = 0.
//   Reset (any state, including mid-op):
//     - FSM goes to IDLE and any in-flight operation is discarded with no response.
//     - All outputs are 0: req_ready, resp_valid, resp_result, resp_cmp, resp_err, alu_ctrl, alu_op1, alu_op2.
//     - While reset is asserted, req_ready = 0.
// TESTING
//   1. req0 ADD 0x7FFFFFFF + 1 -> resp_valid = 2'b01 at T+2, resp_result = 0x80000000, resp_err = 0.
//   2. req1 SUB 5 - 7, TWO_CYCLE_ALU = 1 -> resp_valid = 2'b10 at T+3, resp_result = 0xFFFFFFFE.
//   3. Both requesters valid back-to-back, 4 ops -> grants alternate 0,1,0,1.
//      With ROUND_ROBIN = 0 -> grants are 0,0,0,0 while req0 stays valid.
//   4. req0 LT 0xFFFFFFFF vs 1 -> resp_cmp = 1, resp_result = 1.
//      req0 LTU with the same operands -> resp_cmp = 0, resp_result = 0.
//   5. resp_ready held low for 5 cycles -> result stays stable, req_ready = 0 throughout, no new accept.
//      Then resp_ready[id] = 1 -> IDLE, accept possible on the next cycle.
//   6. Reset asserted in ISSUE -> next cycle all outputs 0, no resp_valid.
//      Illegal op 4'hF -> resp_err = 1, resp_result = 0.

Source files
------------

// File: rtl/picorv32_alu_arbiter.sv
// rtl/picorv32_alu_arbiter.sv - two-requester arbiter sharing one picorv32_alu instance
// Grants one op at a time, drives the ALU from registered operands and returns the captured result.
module picorv32_alu_arbiter #(
  parameter bit TWO_CYCLE_ALU = 1'b0,
  parameter bit ROUND_ROBIN   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [7:0]  req_op,
  input  logic [63:0] req_op1,
  input  logic [63:0] req_op2,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [31:0] resp_result,
  output logic        resp_cmp,
  output logic        resp_err,
  output logic [14:0] alu_ctrl,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  input  logic [31:0] alu_out,
  input  logic        alu_out_0
);

  localparam int C_AND        = 14;
  localparam int C_BEQ        = 12;
  localparam int C_BGE        = 11;
  localparam int C_BGEU       = 10;
  localparam int C_BNE        = 9;
  localparam int C_OR         = 8;
  localparam int C_SUB        = 6;
  localparam int C_XOR        = 5;
  localparam int C_IS_COMPARE = 3;
  localparam int C_IS_ADD_SUB = 2;
  localparam int C_IS_SLT     = 1;
  localparam int C_IS_SLTU    = 0;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state;
  logic        last_grant;
  logic        cur_id;
  logic        cur_err;
  logic [1:0]  grant;
  logic        win_id;
  logic [3:0]  win_op;
  logic [31:0] win_a;
  logic [31:0] win_b;
  logic        accept;
  logic        capture;

  function automatic logic [14:0] decode_op(input logic [3:0] op);
    logic [14:0] c;
    c = '0;
    case (op)
      4'd0:  c[C_IS_ADD_SUB] = 1'b1;
      4'd1:  begin c[C_IS_ADD_SUB] = 1'b1; c[C_SUB] = 1'b1; end
      4'd2:  c[C_XOR] = 1'b1;
      4'd3:  c[C_OR] = 1'b1;
      4'd4:  c[C_AND] = 1'b1;
      4'd5:  begin c[C_BEQ] = 1'b1;     c[C_IS_COMPARE] = 1'b1; end
      4'd6:  begin c[C_BNE] = 1'b1;     c[C_IS_COMPARE] = 1'b1; end
      4'd7:  begin c[C_IS_SLT] = 1'b1;  c[C_IS_COMPARE] = 1'b1; end
      4'd8:  begin c[C_BGE] = 1'b1;     c[C_IS_COMPARE] = 1'b1; end
      4'd9:  begin c[C_IS_SLTU] = 1'b1; c[C_IS_COMPARE] = 1'b1; end
      4'd10: begin c[C_BGEU] = 1'b1;    c[C_IS_COMPARE] = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // On a conflict the pointer names the previous winner; reset leaves it at 1 so req 0 wins first.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (ROUND_ROBIN && !last_grant) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign req_ready = (state == IDLE && !reset) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign win_id    = grant[1];
  assign win_op    = win_id ? req_op[7:4]    : req_op[3:0];
  assign win_a     = win_id ? req_op1[63:32] : req_op1[31:0];
  assign win_b     = win_id ? req_op2[63:32] : req_op2[31:0];
  assign capture   = (state == WAIT) || (state == ISSUE && !TWO_CYCLE_ALU);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      cur_id      <= 1'b0;
      cur_err     <= 1'b0;
      alu_ctrl    <= '0;
      alu_op1     <= '0;
      alu_op2     <= '0;
      resp_valid  <= 2'b00;
      resp_result <= '0;
      resp_cmp    <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= ISSUE;
            last_grant <= win_id;
            cur_id     <= win_id;
            cur_err    <= (win_op > 4'd10);
            alu_ctrl   <= decode_op(win_op);
            alu_op1    <= win_a;
            alu_op2    <= win_b;
          end
        end
        ISSUE: begin
          if (TWO_CYCLE_ALU) state <= WAIT;
        end
        WAIT: ;
        RESP: begin
          if (resp_ready[cur_id]) begin
            state      <= IDLE;
            resp_valid <= 2'b00;
          end
        end
        default: state <= IDLE;
      endcase

      // The ALU is left idle once the result is taken, so its output settles back to 0.
      if (capture) begin
        state       <= RESP;
        resp_valid  <= cur_id ? 2'b10 : 2'b01;
        resp_result <= cur_err ? 32'h0 : alu_out;
        resp_cmp    <= cur_err ? 1'b0 : alu_out_0;
        resp_err    <= cur_err;
        alu_ctrl    <= '0;
        alu_op1     <= '0;
        alu_op2     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_picorv32_alu_arbiter.sv
// tb/tb_picorv32_alu_arbiter.sv - randomized self-checking bench for picorv32_alu_arbiter
// Three instances: single-cycle round-robin, two-cycle round-robin, single-cycle fixed priority.
module tb_picorv32_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset       [3];
  logic [1:0]  req_valid   [3];
  logic [1:0]  req_ready   [3];
  logic [7:0]  req_op      [3];
  logic [63:0] req_op1     [3];
  logic [63:0] req_op2     [3];
  logic [1:0]  resp_valid  [3];
  logic [1:0]  resp_ready  [3];
  logic [31:0] resp_result [3];
  logic        resp_cmp    [3];
  logic        resp_err    [3];
  logic [14:0] alu_ctrl    [3];
  logic [31:0] alu_op1     [3];
  logic [31:0] alu_op2     [3];

  int n_checks = 0;
  int n_fail   = 0;
  int model_last [3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 1) ? 3 : 2;
  endfunction

  function automatic bit rr_of(input int k);
    return (k != 2);
  endfunction

  // picorv32_alu behaviour as seen through its one-hot control inputs
  function automatic logic [32:0] alu_model(input logic [14:0] c, input logic [31:0] x, input logic [31:0] y);
    logic cmp;
    logic [31:0] r;
    cmp = 1'b0;
    r = 32'h0;
    if (c[12])      cmp = (x == y);
    else if (c[9])  cmp = (x != y);
    else if (c[11]) cmp = !($signed(x) < $signed(y));
    else if (c[10]) cmp = !(x < y);
    else if (c[1])  cmp = ($signed(x) < $signed(y));
    else if (c[0])  cmp = (x < y);
    if (c[2])                r = c[6] ? x - y : x + y;
    else if (c[3])           r = {31'h0, cmp};
    else if (c[5] || c[4])   r = x ^ y;
    else if (c[8] || c[7])   r = x | y;
    else if (c[14] || c[13]) r = x & y;
    return {cmp, r};
  endfunction

  // Expected response {err, cmp, result} straight from the op code
  function automatic logic [33:0] ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic c;
    c = 1'b0;
    case (op)
      4'd0:  return {2'b00, a + b};
      4'd1:  return {2'b00, a - b};
      4'd2:  return {2'b00, a ^ b};
      4'd3:  return {2'b00, a | b};
      4'd4:  return {2'b00, a & b};
      4'd5:  c = (a == b);
      4'd6:  c = (a != b);
      4'd7:  c = ($signed(a) < $signed(b));
      4'd8:  c = ($signed(a) >= $signed(b));
      4'd9:  c = (a < b);
      4'd10: c = (a >= b);
      default: return {1'b1, 1'b0, 32'h0};
    endcase
    return {1'b0, c, 31'h0, c};
  endfunction

  function automatic logic [14:0] exp_ctrl(input logic [3:0] op);
    case (op)
      4'd0:    return 15'h0004;
      4'd1:    return 15'h0044;
      4'd2:    return 15'h0020;
      4'd3:    return 15'h0100;
      4'd4:    return 15'h4000;
      4'd5:    return 15'h1008;
      4'd6:    return 15'h0208;
      4'd7:    return 15'h000A;
      4'd8:    return 15'h0808;
      4'd9:    return 15'h0009;
      4'd10:   return 15'h0408;
      default: return 15'h0000;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [32:0] comb;
    logic [32:0] held;
    logic [31:0] alu_out;
    logic        alu_out_0;
    assign comb = alu_model(alu_ctrl[g], alu_op1[g], alu_op2[g]);
    always @(posedge clk) held <= comb;
    assign alu_out   = (g == 1) ? held[31:0] : comb[31:0];
    assign alu_out_0 = (g == 1) ? held[32] : comb[32];

    picorv32_alu_arbiter #(
      .TWO_CYCLE_ALU(g == 1),
      .ROUND_ROBIN  (g != 2)
    ) u_dut (
      .clk        (clk),
      .reset      (reset[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_op     (req_op[g]),
      .req_op1    (req_op1[g]),
      .req_op2    (req_op2[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_result(resp_result[g]),
      .resp_cmp   (resp_cmp[g]),
      .resp_err   (resp_err[g]),
      .alu_ctrl   (alu_ctrl[g]),
      .alu_op1    (alu_op1[g]),
      .alu_op2    (alu_op2[g]),
      .alu_out    (alu_out),
      .alu_out_0  (alu_out_0)
    );
  end

  function automatic int exp_grant(input int k, input logic [1:0] v);
    if (v == 2'b11) return (rr_of(k) && model_last[k] == 0) ? 1 : 0;
    return v[1] ? 1 : 0;
  endfunction

  // One full transaction, entered and left just after a falling edge
  task automatic txn(input int k, input logic [1:0] v, input logic [3:0] op0, input logic [3:0] op1,
                     input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] b0,
                     input logic [31:0] b1, input int hold, output int seen);
    logic [33:0] r;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int g;
    req_valid[k]  = v;
    req_op[k]     = {op1, op0};
    req_op1[k]    = {a1, a0};
    req_op2[k]    = {b1, b0};
    resp_ready[k] = 2'b00;
    #1;
    g = exp_grant(k, v);
    seen = (req_ready[k] == 2'b10) ? 1 : 0;
    check("grant", 64'(req_ready[k]), 64'(2'b01 << g));
    model_last[k] = g;
    op = g ? op1 : op0;
    a  = g ? a1 : a0;
    b  = g ? b1 : b0;
    r  = ref_op(op, a, b);
    @(negedge clk);
    check("issue_ctrl", 64'(alu_ctrl[k]), 64'(exp_ctrl(op)));
    check("issue_op1", 64'(alu_op1[k]), 64'(a));
    check("issue_op2", 64'(alu_op2[k]), 64'(b));
    for (int n = 1; n < lat_of(k); n++) begin
      check("busy_ready", 64'(req_ready[k]), 64'(0));
      check("early_resp", 64'(resp_valid[k]), 64'(0));
      @(negedge clk);
    end
    check("resp_valid", 64'(resp_valid[k]), 64'(2'b01 << g));
    check("resp_result", 64'(resp_result[k]), 64'(r[31:0]));
    check("resp_err", 64'(resp_err[k]), 64'(r[33]));
    if (op >= 4'd5) check("resp_cmp", 64'(resp_cmp[k]), 64'(r[32]));
    check("resp_alu_ctrl", 64'(alu_ctrl[k]), 64'(0));
    check("resp_alu_ops", 64'(alu_op1[k] | alu_op2[k]), 64'(0));
    for (int h = 0; h < hold; h++) begin
      resp_ready[k] = 2'b01 << (1 - g);
      @(negedge clk);
      check("hold_valid", 64'(resp_valid[k]), 64'(2'b01 << g));
      check("hold_result", 64'(resp_result[k]), 64'(r[31:0]));
      check("hold_ready", 64'(req_ready[k]), 64'(0));
    end
    resp_ready[k] = 2'b01 << g;
    @(negedge clk);
    resp_ready[k] = 2'b00;
    check("resp_done", 64'(resp_valid[k]), 64'(0));
    check("next_ready", 64'(req_ready[k]), 64'(2'b01 << exp_grant(k, v)));
    req_valid[k] = 2'b00;
  endtask

  task automatic do_reset(input int k);
    reset[k]      = 1'b1;
    req_valid[k]  = 2'b00;
    resp_ready[k] = 2'b00;
    @(negedge clk);
    reset[k]      = 1'b0;
    model_last[k] = 1;
  endtask

  task automatic reset_mid(input int k);
    req_valid[k]  = 2'b01;
    req_op[k]     = 8'h00;
    req_op1[k]    = 64'h1;
    req_op2[k]    = 64'h2;
    resp_ready[k] = 2'b00;
    @(negedge clk);
    check("mid_issue_ctrl", 64'(alu_ctrl[k]), 64'(exp_ctrl(4'd0)));
    reset[k] = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready[k]), 64'(0));
    check("rst_resp_valid", 64'(resp_valid[k]), 64'(0));
    check("rst_resp_result", 64'(resp_result[k]), 64'(0));
    check("rst_resp_flags", 64'({resp_cmp[k], resp_err[k]}), 64'(0));
    check("rst_alu_ctrl", 64'(alu_ctrl[k]), 64'(0));
    check("rst_alu_ops", 64'(alu_op1[k] | alu_op2[k]), 64'(0));
    reset[k]      = 1'b0;
    req_valid[k]  = 2'b00;
    model_last[k] = 1;
    repeat (4) begin
      @(negedge clk);
      check("rst_no_resp", 64'(resp_valid[k]), 64'(0));
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    logic [31:0] ra0, ra1, rb0, rb1;
    for (int k = 0; k < 3; k++) begin
      reset[k]      = 1'b1;
      req_valid[k]  = 2'b00;
      req_op[k]     = 8'h00;
      req_op1[k]    = 64'h0;
      req_op2[k]    = 64'h0;
      resp_ready[k] = 2'b00;
      model_last[k] = 1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 2'b11;
      #1;
      check("reset_req_ready", 64'(req_ready[k]), 64'(0));
      check("reset_resp_valid", 64'(resp_valid[k]), 64'(0));
      check("reset_alu_ctrl", 64'(alu_ctrl[k]), 64'(0));
      check("reset_resp_result", 64'(resp_result[k]), 64'(0));
      req_valid[k] = 2'b00;
    end
    for (int k = 0; k < 3; k++) reset[k] = 1'b0;
    @(negedge clk);

    txn(0, 2'b01, 4'd0, 4'd3, 32'h7FFF_FFFF, 32'h0, 32'h1, 32'h0, 0, seen);
    txn(1, 2'b10, 4'd0, 4'd1, 32'h0, 32'd5, 32'h0, 32'd7, 0, seen);
    txn(0, 2'b01, 4'd7, 4'd0, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0, 0, seen);
    txn(0, 2'b01, 4'd9, 4'd0, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0, 0, seen);
    txn(0, 2'b11, 4'd2, 4'd4, 32'h1234_5678, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFF00_FF00, 5, seen);
    txn(0, 2'b01, 4'hF, 4'd0, 32'hDEAD_BEEF, 32'h0, 32'h1, 32'h0, 1, seen);

    for (int k = 0; k < 3; k += 2) begin
      do_reset(k);
      for (int i = 0; i < 4; i++) begin
        txn(k, 2'b11, 4'd0, 4'd1, 32'd10 + i, 32'd20, 32'd3, 32'd4, 0, seen);
        check("grant_order", 64'(seen), 64'((k == 2) ? 0 : (i % 2)));
      end
    end

    for (int k = 0; k < 3; k++) reset_mid(k);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 40; i++) begin
        ra0 = pick();
        ra1 = pick();
        rb0 = ($urandom_range(0, 3) == 0) ? ra0 : pick();
        rb1 = ($urandom_range(0, 3) == 0) ? ra1 : pick();
        txn(k, 2'($urandom_range(1, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            ra0, ra1, rb0, rb1, $urandom_range(0, 3), seen);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
